// File: rtl/flag_pkg.sv
// Shared constants for the flag unit: flag bit positions, opcodes and the
// per-opcode flag update mask.
package flag_pkg;

   localparam int FLAG_Z = 0;
   localparam int FLAG_O = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 3;

   localparam int unsigned OP_ADD  = 32'h00;
   localparam int unsigned OP_SUB  = 32'h01;
   localparam int unsigned OP_ADDI = 32'h02;
   localparam int unsigned OP_AND  = 32'h03;
   localparam int unsigned OP_OR   = 32'h04;
   localparam int unsigned OP_XOR  = 32'h05;
   localparam int unsigned OP_NOT  = 32'h06;
   localparam int unsigned OP_INV  = 32'h07;
   localparam int unsigned OP_ROR  = 32'h08;
   localparam int unsigned OP_ROL  = 32'h09;
   localparam int unsigned OP_SHR  = 32'h0A;
   localparam int unsigned OP_SHL  = 32'h0B;
   localparam int unsigned OP_LDIF = 32'h19;
   localparam int unsigned OP_MOVF = 32'h1A;

   // LDIF, MOVF and unlisted opcodes return an empty mask; the caller handles them.
   function automatic logic [31:0] upd_mask(input logic [31:0] op, input int flag_w);
      logic [31:0] m;
      m = '0;
      if (op <= OP_ADDI) begin
         m[FLAG_C] = 1'b1;
         m[FLAG_N] = 1'b1;
         m[FLAG_O] = 1'b1;
         m[FLAG_Z] = 1'b1;
      end else if (op <= OP_INV) begin
         m[FLAG_N] = 1'b1;
         m[FLAG_Z] = 1'b1;
      end else if (op <= OP_SHL) begin
         m[FLAG_C] = 1'b1;
         m[FLAG_N] = 1'b1;
         m[FLAG_Z] = 1'b1;
      end
      if (flag_w < 32) m = m & ((32'd1 << flag_w) - 32'd1);
      return m;
   endfunction

endpackage

// File: rtl/flag_unit_stack.sv
// LIFO context stack for the flag word: push, pop, or swap (push+pop with a
// non-empty stack replaces the top entry). Entries are not reset.
module flag_stack #(
   parameter int FLAG_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [FLAG_W-1:0]          din,
   output logic [FLAG_W-1:0]          top,
   output logic [$clog2(DEPTH+1)-1:0] depth,
   output logic                       full,
   output logic                       empty
);

   localparam int DW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [FLAG_W-1:0] mem_q [DEPTH];
   logic [FLAG_W-1:0] mem_d [DEPTH];
   logic [DW-1:0]     depth_q, depth_d;
   logic [AW-1:0]     wr_idx, top_idx;

   assign full    = (depth_q == DW'(DEPTH));
   assign empty   = (depth_q == '0);
   assign depth   = depth_q;
   assign wr_idx  = AW'(depth_q);
   assign top_idx = AW'(depth_q - DW'(1));
   assign top     = empty ? '0 : mem_q[top_idx];

   always_comb begin
      mem_d   = mem_q;
      depth_d = depth_q;
      if (push && pop && !empty) begin
         mem_d[top_idx] = din;
      end else if (push) begin
         // an empty stack turns push+pop into a plain push
         if (!full) begin
            mem_d[wr_idx] = din;
            depth_d       = depth_q + DW'(1);
         end
      end else if (pop && !empty) begin
         depth_d = depth_q - DW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) depth_q <= '0;
      else     depth_q <= depth_d;
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/flag_unit.sv
// Architectural flag register: merges ALU flags under opcode masks, executes
// LDIF/MOVF, and saves/restores the flag word through a context stack.
module flag_unit
   import flag_pkg::*;
#(
   parameter int FLAG_W = 8,
   parameter int OPC_W  = 5,
   parameter int DEPTH  = 4,
   parameter int A_BIT  = 5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [FLAG_W-1:0]           f,
   input  logic [OPC_W-1:0]            op,
   input  logic                        op_valid,
   input  logic [$clog2(FLAG_W)-1:0]   sel,
   input  logic                        val,
   input  logic                        push,
   input  logic                        pop,
   input  logic                        err_clr,
   output logic [FLAG_W-1:0]           q,
   output logic [$clog2(DEPTH+1)-1:0]  depth,
   output logic                        full,
   output logic                        empty,
   output logic                        err_ovf,
   output logic                        err_udf
);

   localparam logic [FLAG_W-1:0] A_MASK = FLAG_W'(1) << A_BIT;

   logic [FLAG_W-1:0] q_q, q_d;
   logic [FLAG_W-1:0] top, f_upd, mask;
   logic [31:0]       op_ext, m32;
   logic              ovf_q, ovf_d, udf_q, udf_d;
   logic              pop_hit, ovf_set, udf_set;

   flag_stack #(
      .FLAG_W (FLAG_W),
      .DEPTH  (DEPTH)
   ) u_stack (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (q_q),
      .top   (top),
      .depth (depth),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      op_ext = 32'(op);
      m32    = upd_mask(op_ext, FLAG_W);
      mask   = m32[FLAG_W-1:0];
      f_upd  = q_q;
      if (op_valid) begin
         if (op_ext == OP_LDIF) begin
            // the top bit is reserved and A is hard-wired, so LDIF skips both
            if (int'(sel) != A_BIT && int'(sel) < FLAG_W - 1) f_upd[sel] = val;
         end else if (op_ext == OP_MOVF) begin
            if (!val) f_upd = f;
         end else begin
            f_upd = (q_q & ~mask) | (f & mask);
         end
      end

      // a successful pop (or swap) restores from the stack and drops the op
      pop_hit = pop & ~empty;
      q_d     = (pop_hit ? top : f_upd) | A_MASK;

      ovf_set = push & ~pop & full;
      udf_set = pop & ~push & empty;
      ovf_d   = ovf_set | (ovf_q & ~err_clr);
      udf_d   = udf_set | (udf_q & ~err_clr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q   <= A_MASK;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign q       = q_q;
   assign err_ovf = ovf_q;
   assign err_udf = udf_q;

endmodule

// File: tb/tb_flag_unit.sv
// Directed and randomized bench for flag_unit against a queue-based reference
// model of the flag word, context stack and sticky error flags.
module tb_flag_unit;

   logic       clk = 1'b0;
   logic       rst, op_valid, val, push, pop, err_clr;
   logic [7:0] f;
   logic [4:0] op;
   logic [2:0] sel;
   logic [7:0] q;
   logic [2:0] depth;
   logic       full, empty, err_ovf, err_udf;

   int checks = 0;
   int errors = 0;

   logic [7:0] m_q;
   logic [7:0] m_stk[$];
   logic       m_ovf, m_udf;

   flag_unit dut (
      .clk      (clk),
      .rst      (rst),
      .f        (f),
      .op       (op),
      .op_valid (op_valid),
      .sel      (sel),
      .val      (val),
      .push     (push),
      .pop      (pop),
      .err_clr  (err_clr),
      .q        (q),
      .depth    (depth),
      .full     (full),
      .empty    (empty),
      .err_ovf  (err_ovf),
      .err_udf  (err_udf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Flag word after an instruction, from the opcode table: Z=0 O=1 N=2 C=3 A=5.
   function automatic logic [7:0] model_op(input logic [7:0] cur, input bit v, input int o,
                                           input logic [7:0] fi, input int s, input bit b);
      logic [7:0] r;
      r = cur;
      if (v) begin
         if (o >= 0 && o <= 2)       r = (cur & 8'hF0) | (fi & 8'h0F);
         else if (o >= 3 && o <= 7)  r = (cur & 8'hFA) | (fi & 8'h05);
         else if (o >= 8 && o <= 11) r = (cur & 8'hF2) | (fi & 8'h0D);
         else if (o == 25) begin
            if (s != 5 && s < 7) r[s] = b;
         end else if (o == 26) begin
            if (!b) r = fi;
         end
      end
      return r | 8'h20;
   endfunction

   task automatic step(input bit i_rst, input bit i_push, input bit i_pop, input bit i_clr,
                       input bit i_opv, input logic [4:0] i_op, input logic [7:0] i_f,
                       input logic [2:0] i_sel, input bit i_val);
      logic [7:0] nq;
      bit nov, nud;
      rst = i_rst; push = i_push; pop = i_pop; err_clr = i_clr;
      op_valid = i_opv; op = i_op; f = i_f; sel = i_sel; val = i_val;

      nq  = model_op(m_q, i_opv, int'(i_op), i_f, int'(i_sel), i_val);
      nov = i_clr ? 1'b0 : m_ovf;
      nud = i_clr ? 1'b0 : m_udf;
      if (i_rst) begin
         nq = 8'h20; nov = 0; nud = 0;
         m_stk.delete();
      end else if (i_push && i_pop && m_stk.size() > 0) begin
         nq = m_stk[$] | 8'h20;
         m_stk[$] = m_q;
      end else if (i_pop && !i_push) begin
         if (m_stk.size() > 0) nq = m_stk.pop_back() | 8'h20;
         else nud = 1'b1;
      end else if (i_push) begin
         if (m_stk.size() < 4) m_stk.push_back(m_q);
         else nov = 1'b1;
      end
      m_q = nq; m_ovf = nov; m_udf = nud;

      @(posedge clk);
      #1;
      check("q", 32'(q), 32'(m_q));
      check("depth", 32'(depth), 32'(m_stk.size()));
      check("full", 32'(full), 32'(m_stk.size() == 4));
      check("empty", 32'(empty), 32'(m_stk.size() == 0));
      check("err_ovf", 32'(err_ovf), 32'(m_ovf));
      check("err_udf", 32'(err_udf), 32'(m_udf));
   endtask

   // shorthand: op only, no stack activity
   task automatic do_op(input logic [4:0] o, input logic [7:0] fi, input logic [2:0] s, input bit b);
      step(0, 0, 0, 0, 1, o, fi, s, b);
   endtask

   initial begin
      m_q = 8'h20; m_ovf = 0; m_udf = 0;
      rst = 1; push = 0; pop = 0; err_clr = 0; op_valid = 0; op = '0; f = '0; sel = '0; val = 0;
      @(negedge clk);
      step(1, 0, 0, 0, 0, 5'h00, 8'h00, 3'd0, 0);
      check("reset_q", 32'(q), 32'h20);
      check("reset_empty", 32'(empty), 32'h1);

      do_op(5'h00, 8'hFF, 3'd0, 0);
      check("add_ff", 32'(q), 32'h2F);
      do_op(5'h03, 8'h00, 3'd0, 0);
      check("and_00", 32'(q), 32'h2A);
      do_op(5'h19, 8'h00, 3'd7, 1);
      check("ldif_sel7", 32'(q), 32'h2A);
      do_op(5'h19, 8'h00, 3'd5, 0);
      check("ldif_sel5", 32'(q), 32'h2A);
      do_op(5'h19, 8'h00, 3'd4, 1);
      check("ldif_sel4", 32'(q), 32'h3A);
      do_op(5'h1A, 8'h00, 3'd0, 0);
      check("movf_00", 32'(q), 32'h20);
      do_op(5'h1A, 8'hFF, 3'd0, 1);
      check("movf_hold", 32'(q), 32'h20);
      do_op(5'h08, 8'hFF, 3'd0, 0);
      check("ror_ff", 32'(q), 32'h2D);
      do_op(5'h12, 8'hFF, 3'd0, 0);
      check("unused_op", 32'(q), 32'h2D);

      // fill the stack with 0x21, 0x22, 0x24, 0x28
      do_op(5'h1A, 8'h21, 3'd0, 0);
      step(0, 1, 0, 0, 1, 5'h1A, 8'h22, 3'd0, 0);
      step(0, 1, 0, 0, 1, 5'h1A, 8'h24, 3'd0, 0);
      step(0, 1, 0, 0, 1, 5'h1A, 8'h28, 3'd0, 0);
      step(0, 1, 0, 0, 0, 5'h00, 8'h00, 3'd0, 0);
      check("full_after4", 32'(full), 32'h1);
      step(0, 1, 0, 0, 0, 5'h00, 8'h00, 3'd0, 0);
      check("ovf_set", 32'(err_ovf), 32'h1);
      check("ovf_depth", 32'(depth), 32'h4);
      step(0, 0, 1, 0, 0, 5'h00, 8'h00, 3'd0, 0);
      check("pop1", 32'(q), 32'h28);
      step(0, 0, 1, 0, 1, 5'h00, 8'hFF, 3'd0, 0);
      check("pop2_op_dropped", 32'(q), 32'h24);
      step(0, 0, 1, 0, 0, 5'h00, 8'h00, 3'd0, 0);
      check("pop3", 32'(q), 32'h22);
      step(0, 0, 1, 0, 0, 5'h00, 8'h00, 3'd0, 0);
      check("pop4", 32'(q), 32'h21);
      step(0, 0, 1, 0, 0, 5'h00, 8'h00, 3'd0, 0);
      check("udf_set", 32'(err_udf), 32'h1);
      check("udf_q_hold", 32'(q), 32'h21);

      // clear errors, then push with a simultaneous ADD, then swap
      step(0, 0, 0, 1, 1, 5'h1A, 8'h00, 3'd0, 0);
      check("err_clr", 32'({err_ovf, err_udf}), 32'h0);
      step(0, 1, 0, 0, 1, 5'h00, 8'h01, 3'd0, 0);
      check("push_add", 32'(q), 32'h21);
      step(0, 1, 1, 0, 1, 5'h00, 8'h0F, 3'd0, 0);
      check("swap_q", 32'(q), 32'h20);
      check("swap_depth", 32'(depth), 32'h1);
      step(0, 0, 1, 0, 0, 5'h00, 8'h00, 3'd0, 0);
      check("swap_top", 32'(q), 32'h21);
      // push+pop on an empty stack acts as a push
      step(0, 1, 1, 0, 0, 5'h00, 8'h00, 3'd0, 0);
      check("pp_empty", 32'(depth), 32'h1);

      // reset in mid-operation with depth 3 and err_ovf set
      step(0, 1, 0, 0, 0, 5'h00, 8'h00, 3'd0, 0);
      step(0, 1, 0, 0, 0, 5'h00, 8'h00, 3'd0, 0);
      step(0, 1, 0, 0, 0, 5'h00, 8'h00, 3'd0, 0);
      step(0, 1, 0, 0, 0, 5'h00, 8'h00, 3'd0, 0);
      step(0, 0, 1, 0, 0, 5'h00, 8'h00, 3'd0, 0);
      check("pre_rst_ovf", 32'(err_ovf), 32'h1);
      check("pre_rst_depth", 32'(depth), 32'h3);
      step(1, 1, 0, 0, 1, 5'h00, 8'hFF, 3'd0, 0);
      check("rst_q", 32'(q), 32'h20);
      check("rst_depth", 32'(depth), 32'h0);
      check("rst_ovf", 32'(err_ovf), 32'h0);

      // randomized traffic, biased toward defined opcodes
      for (int i = 0; i < 400; i++) begin
         logic [4:0] ro;
         int k;
         k = $urandom_range(0, 15);
         if (k < 12)       ro = 5'(k);
         else if (k == 12) ro = 5'h19;
         else if (k == 13) ro = 5'h1A;
         else              ro = 5'($urandom_range(0, 31));
         step($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, ro, 8'($urandom()),
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
